tug_match_scorer: RTL and testbench

//  Parametrised successor to the tug-of-war round scorer. Tracks rope position over
//  +/-SIDE_STEPS, applies the jump-the-light and fake-state penalty and favour-the-loser

---
 rtl/tug_pkg.sv | 15 +
 rtl/tug_pos_decode.sv | 34 +++
 rtl/tug_match_scorer.sv | 138 +++++++++++++
 tb/tb_tug_match_scorer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared types and sizing helpers for the tug-of-war match scorer.
//   phase_e : round/match phase
//   pos_w   : signed width able to hold -(S+1)..+(S+1)
//   leds    : LED vector width for S steps per side
package tug_pkg;
  typedef enum logic [1:0] {PLAY = 2'd0, WON = 2'd1, MATCH_DONE = 2'd2} phase_e;

  function automatic int pos_w(input int s);
    return $clog2(s + 2) + 1;
  endfunction

  function automatic int leds(input int s);
    return 2 * s + 1;
  endfunction
endpackage

// File: rtl/tug_pos_decode.sv
// Rope position -> LED vector (purely combinational).
//   pos   : signed rope position, +ve = right
//   phase : current phase; outside PLAY the win bar is shown
//   score : MSB = outermost left, LSB = outermost right
module tug_pos_decode
  import tug_pkg::*;
#(
  parameter int S  = 3,
  parameter int PW = pos_w(S)
) (
  input  logic signed [PW-1:0]  pos,
  input  phase_e                phase,
  output logic [leds(S)-1:0]    score
);
  localparam logic signed [PW-1:0] P_W = PW'(S + 1);
  localparam logic signed [PW-1:0] N_W = PW'(-(S + 1));

  logic in_play, r_win, l_win;
  assign in_play = (phase == PLAY);
  assign r_win   = !in_play && (pos == P_W);
  assign l_win   = !in_play && (pos == N_W);

  // LED i lights for pos == S-i; a win fills that player's half.
  for (genvar i = 0; i < leds(S); i++) begin : g_led
    localparam logic signed [PW-1:0] AT = PW'(S - i);
    if (i < S) begin : g_r
      assign score[i] = in_play ? (pos == AT) : r_win;
    end else if (i > S) begin : g_l
      assign score[i] = in_play ? (pos == AT) : l_win;
    end else begin : g_c
      assign score[i] = in_play && (pos == AT);
    end
  end
endmodule

// File: rtl/tug_match_scorer.sv
// Tug-of-war round and match scorer.
//   clk, rst               : clock, async active-high reset
//   winrnd/right/tie       : resolved push from the arbiter
//   leds_on/fake           : penalty qualifiers (jumped light / fake state)
//   new_game/new_match     : next round / clear match
//   score                  : LED vector (combinational decode of state)
//   round_won/winner_right : win pulse and side of last round won
//   wins_l/wins_r          : rounds won per player, saturating
//   match_over             : match decided
module tug_match_scorer
  import tug_pkg::*;
#(
  parameter int SIDE_STEPS   = 3,
  parameter int MATCH_WINS   = 2,
  parameter int FAVOUR_LOSER = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winrnd,
  input  logic                  right,
  input  logic                  tie,
  input  logic                  leds_on,
  input  logic                  fake,
  input  logic                  new_game,
  input  logic                  new_match,
  output logic [2*SIDE_STEPS:0] score,
  output logic                  round_won,
  output logic                  winner_right,
  output logic [3:0]            wins_l,
  output logic [3:0]            wins_r,
  output logic                  match_over
);
  localparam int PW = pos_w(SIDE_STEPS);
  localparam logic signed [PW-1:0] P_S = PW'(SIDE_STEPS);
  localparam logic signed [PW-1:0] N_S = PW'(-SIDE_STEPS);
  localparam logic signed [PW-1:0] P_W = PW'(SIDE_STEPS + 1);
  localparam logic signed [PW-1:0] N_W = PW'(-(SIDE_STEPS + 1));
  localparam logic signed [PW-1:0] P_1 = PW'(1);
  localparam logic signed [PW-1:0] N_1 = PW'(-1);
  localparam logic [3:0]           MW  = 4'(MATCH_WINS);

  phase_e                phase_q, phase_n;
  logic signed [PW-1:0]  pos_q, pos_n, step;
  logic                  rw_q, rw_n, wr_side_q, wr_side_n;
  logic [3:0]            wl_q, wl_n, wr_q, wr_n;
  logic                  point, invalid, to_right;

  assign point    = winrnd && !tie && (phase_q == PLAY);
  assign invalid  = !leds_on || fake;
  // A penalty awards the point to the other player.
  assign to_right = right ^ invalid;

  // Candidate position after a point.
  always_comb begin
    step = to_right ? pos_q + P_1 : pos_q + N_1;
    if (pos_q == P_S && to_right)                                      step = P_W;
    else if (pos_q == N_S && !to_right)                                step = N_W;
    else if (FAVOUR_LOSER != 0 && !invalid && pos_q == P_S && !to_right) step = P_1;
    else if (FAVOUR_LOSER != 0 && !invalid && pos_q == N_S && to_right)  step = N_1;
  end

  always_comb begin
    phase_n   = phase_q;
    pos_n     = pos_q;
    rw_n      = 1'b0;
    wr_side_n = wr_side_q;
    wl_n      = wl_q;
    wr_n      = wr_q;
    if (new_match) begin
      phase_n = PLAY;
      pos_n   = '0;
      wl_n    = '0;
      wr_n    = '0;
    end else begin
      case (phase_q)
        PLAY: begin
          if (new_game) begin
            pos_n = '0;               // round abort; a same-cycle point is dropped
          end else if (point) begin
            pos_n = step;
            if (step == P_W || step == N_W) begin
              rw_n      = 1'b1;
              wr_side_n = (step == P_W);
              if (step == P_W) begin
                if (wr_q < MW) wr_n = wr_q + 4'd1;
                phase_n = (wr_n == MW) ? MATCH_DONE : WON;
              end else begin
                if (wl_q < MW) wl_n = wl_q + 4'd1;
                phase_n = (wl_n == MW) ? MATCH_DONE : WON;
              end
            end
          end
        end
        WON: begin
          if (new_game) begin
            phase_n = PLAY;
            pos_n   = '0;
          end
        end
        MATCH_DONE: ;
        default: begin
          phase_n = PLAY;
          pos_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PLAY;
      pos_q     <= '0;
      rw_q      <= 1'b0;
      wr_side_q <= 1'b0;
      wl_q      <= '0;
      wr_q      <= '0;
    end else begin
      phase_q   <= phase_n;
      pos_q     <= pos_n;
      rw_q      <= rw_n;
      wr_side_q <= wr_side_n;
      wl_q      <= wl_n;
      wr_q      <= wr_n;
    end
  end

  tug_pos_decode #(.S(SIDE_STEPS), .PW(PW)) u_dec (
    .pos   (pos_q),
    .phase (phase_q),
    .score (score)
  );

  assign round_won    = rw_q;
  assign winner_right = wr_side_q;
  assign wins_l       = wl_q;
  assign wins_r       = wr_q;
  assign match_over   = (phase_q == MATCH_DONE);
endmodule

// File: tb/tb_tug_match_scorer.sv
// Directed bench for tug_match_scorer (S=3, MATCH_WINS=2). A second instance with
// FAVOUR_LOSER=0 shares the stimulus. Expected outputs go into a queue as each step
// is driven and are popped and compared once the step has been clocked.
module tb_tug_match_scorer;
  logic clk = 1'b0;
  logic rst, winrnd, right, tie, leds_on, fake, new_game, new_match;
  logic [6:0] score1, score0;
  logic       rw1, rw0, ws1, ws0, mo1, mo0;
  logic [3:0] wl1, wl0, wr1, wr0;

  always #5 clk = ~clk;

  tug_match_scorer #(.SIDE_STEPS(3), .MATCH_WINS(2), .FAVOUR_LOSER(1)) dut (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie),
    .leds_on(leds_on), .fake(fake), .new_game(new_game), .new_match(new_match),
    .score(score1), .round_won(rw1), .winner_right(ws1), .wins_l(wl1),
    .wins_r(wr1), .match_over(mo1));

  tug_match_scorer #(.SIDE_STEPS(3), .MATCH_WINS(2), .FAVOUR_LOSER(0)) dut0 (
    .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie),
    .leds_on(leds_on), .fake(fake), .new_game(new_game), .new_match(new_match),
    .score(score0), .round_won(rw0), .winner_right(ws0), .wins_l(wl0),
    .wins_r(wr0), .match_over(mo0));

  // Input words: {winrnd,right,tie,leds_on,fake,new_game,new_match}
  localparam logic [6:0] IDLE = 7'b0001000;
  localparam logic [6:0] PR   = 7'b1101000;  // valid right push
  localparam logic [6:0] PL   = 7'b1001000;  // valid left push
  localparam logic [6:0] NG   = 7'b0001010;
  localparam logic [6:0] NGP  = 7'b1101010;  // new_game with a push
  localparam logic [6:0] NMP  = 7'b1101001;  // new_match with a push
  localparam logic [6:0] JMP  = 7'b1100000;  // right pushes, lights off
  localparam logic [6:0] FAK  = 7'b1001100;  // left pushes in fake state
  localparam logic [6:0] TIE  = 7'b1111000;

  typedef struct {
    string       tag;
    logic [17:0] e1;
    logic [17:0] e0;
  } exp_t;
  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [17:0] ov(logic [6:0] s, logic rw, logic ws,
                                     logic [3:0] wl, logic [3:0] wr, logic mo);
    return {s, rw, ws, wl, wr, mo};
  endfunction

  task automatic pop_check();
    exp_t e;
    logic [17:0] o1, o0;
    e  = sb.pop_front();
    o1 = {score1, rw1, ws1, wl1, wr1, mo1};
    o0 = {score0, rw0, ws0, wl0, wr0, mo0};
    n_cmp++;
    assert (o1 === e.e1) else begin
      n_fail++;
      $error("FAIL %s fl1: observed %b expected %b", e.tag, o1, e.e1);
    end
    n_cmp++;
    assert (o0 === e.e0) else begin
      n_fail++;
      $error("FAIL %s fl0: observed %b expected %b", e.tag, o0, e.e0);
    end
  endtask

  // Drive one cycle of inputs, clock it, compare 1 time unit after the edge.
  task automatic stepd(input string tag, input logic [6:0] in,
                       input logic [17:0] e1, input logic [17:0] e0);
    exp_t e;
    {winrnd, right, tie, leds_on, fake, new_game, new_match} = in;
    e.tag = tag; e.e1 = e1; e.e0 = e0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    {winrnd, right, tie, leds_on, fake, new_game, new_match} = IDLE;
    pop_check();
  endtask

  task automatic step(input string tag, input logic [6:0] in, input logic [17:0] e);
    stepd(tag, in, e, e);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    {winrnd, right, tie, leds_on, fake, new_game, new_match} = IDLE;
    #2;
    e.tag = "reset"; e.e1 = ov(7'b0001000, 0, 0, 0, 0, 0); e.e0 = e.e1;
    sb.push_back(e);
    pop_check();
    @(posedge clk); #1;
    rst = 1'b0;
    step("idle_after_reset", IDLE, ov(7'b0001000, 0, 0, 0, 0, 0));

    // right wins the first round
    step("r_push1", PR, ov(7'b0000100, 0, 0, 0, 0, 0));
    step("r_push2", PR, ov(7'b0000010, 0, 0, 0, 0, 0));
    step("r_push3", PR, ov(7'b0000001, 0, 0, 0, 0, 0));
    step("r_win1",  PR, ov(7'b0000111, 1, 1, 0, 1, 0));
    step("pulse_end", IDLE, ov(7'b0000111, 0, 1, 0, 1, 0));
    step("push_in_won", PL, ov(7'b0000111, 0, 1, 0, 1, 0));
    step("new_game", NG, ov(7'b0001000, 0, 1, 0, 1, 0));

    // favour-the-loser from the right outer step
    step("to_p1", PR, ov(7'b0000100, 0, 1, 0, 1, 0));
    step("to_p2", PR, ov(7'b0000010, 0, 1, 0, 1, 0));
    step("to_p3", PR, ov(7'b0000001, 0, 1, 0, 1, 0));
    stepd("favour_right_lead", PL, ov(7'b0000100, 0, 1, 0, 1, 0),
                                   ov(7'b0000010, 0, 1, 0, 1, 0));
    step("abort_drops_point", NGP, ov(7'b0001000, 0, 1, 0, 1, 0));

    // mirror on the left
    step("to_m1", PL, ov(7'b0010000, 0, 1, 0, 1, 0));
    step("to_m2", PL, ov(7'b0100000, 0, 1, 0, 1, 0));
    step("to_m3", PL, ov(7'b1000000, 0, 1, 0, 1, 0));
    stepd("favour_left_lead", PR, ov(7'b0010000, 0, 1, 0, 1, 0),
                                  ov(7'b0100000, 0, 1, 0, 1, 0));
    step("abort2", NG, ov(7'b0001000, 0, 1, 0, 1, 0));

    // penalties
    step("jump_light", JMP, ov(7'b0010000, 0, 1, 0, 1, 0));
    step("abort3", NG, ov(7'b0001000, 0, 1, 0, 1, 0));
    step("fake_push", FAK, ov(7'b0000100, 0, 1, 0, 1, 0));
    step("abort4", NG, ov(7'b0001000, 0, 1, 0, 1, 0));
    step("pen_p1", PR, ov(7'b0000100, 0, 1, 0, 1, 0));
    step("pen_p2", PR, ov(7'b0000010, 0, 1, 0, 1, 0));
    step("pen_p3", PR, ov(7'b0000001, 0, 1, 0, 1, 0));
    step("penalty_no_favour", JMP, ov(7'b0000010, 0, 1, 0, 1, 0));
    step("abort5", NG, ov(7'b0001000, 0, 1, 0, 1, 0));
    step("tie", TIE, ov(7'b0001000, 0, 1, 0, 1, 0));

    // second right round win decides the match
    step("m_p1", PR, ov(7'b0000100, 0, 1, 0, 1, 0));
    step("m_p2", PR, ov(7'b0000010, 0, 1, 0, 1, 0));
    step("m_p3", PR, ov(7'b0000001, 0, 1, 0, 1, 0));
    step("match_win", PR, ov(7'b0000111, 1, 1, 0, 2, 1));
    step("match_hold", IDLE, ov(7'b0000111, 0, 1, 0, 2, 1));
    step("ng_ignored", NG, ov(7'b0000111, 0, 1, 0, 2, 1));
    step("push_in_done", PL, ov(7'b0000111, 0, 1, 0, 2, 1));
    step("new_match", NMP, ov(7'b0001000, 0, 1, 0, 0, 0));

    // left wins a round, then reset while in WON
    step("l_p1", PL, ov(7'b0010000, 0, 1, 0, 0, 0));
    step("l_p2", PL, ov(7'b0100000, 0, 1, 0, 0, 0));
    step("l_p3", PL, ov(7'b1000000, 0, 1, 0, 0, 0));
    step("l_win", PL, ov(7'b1110000, 1, 0, 1, 0, 0));
    step("l_hold", IDLE, ov(7'b1110000, 0, 0, 1, 0, 0));
    rst = 1'b1;
    #1;
    e.tag = "async_rst"; e.e1 = ov(7'b0001000, 0, 0, 0, 0, 0); e.e0 = e.e1;
    sb.push_back(e);
    pop_check();
    step("rst_held", IDLE, ov(7'b0001000, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step("after_rst", IDLE, ov(7'b0001000, 0, 0, 0, 0, 0));
    step("push_after_rst", PR, ov(7'b0000100, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
